// File: rtl/iq_frame_sequencer.sv
// -----------------------------------------------------------------------------
// iq_frame_sequencer
//
// Joins separate I and Q AXI4-Stream sample streams into paired {I,Q} beats
// and cuts them into fixed-length symbol frames for the CNN demodulator.
// A short final frame is padded with zero beats. The number of frames issued
// to the CNN without a returned demodulated bit is limited by a credit counter.
//
// Ports:
//   clock, resetn          system clock, asynchronous active-low reset
//   enable                 level-sensitive run request
//   s_axis_i_*             I sample stream (tdata/tvalid/tready/tlast)
//   s_axis_q_*             Q sample stream (tdata/tvalid/tready/tlast)
//   m_axis_tdata           {I, Q}, I in the upper half
//   m_axis_tvalid/tready   output handshake
//   m_axis_tlast           last beat of a frame
//   m_axis_tuser           first beat of a frame
//   bit_done               one-cycle credit return from the CNN
//   frames_sent            frames issued since reset (wraps)
//   in_flight              frames outstanding in the CNN
//   busy                   high whenever the sequencer is not idle
//   err_misalign           sticky flag: I and Q tlast disagreed on a joined beat
// -----------------------------------------------------------------------------
module iq_frame_sequencer #(
  parameter int DATA_W       = 16,
  parameter int SPS          = 8,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                                  clock,
  input  logic                                  resetn,
  input  logic                                  enable,
  input  logic [DATA_W-1:0]                     s_axis_i_tdata,
  input  logic                                  s_axis_i_tvalid,
  output logic                                  s_axis_i_tready,
  input  logic                                  s_axis_i_tlast,
  input  logic [DATA_W-1:0]                     s_axis_q_tdata,
  input  logic                                  s_axis_q_tvalid,
  output logic                                  s_axis_q_tready,
  input  logic                                  s_axis_q_tlast,
  output logic [2*DATA_W-1:0]                   m_axis_tdata,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic                                  m_axis_tlast,
  output logic                                  m_axis_tuser,
  input  logic                                  bit_done,
  output logic [CNT_W-1:0]                      frames_sent,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]     in_flight,
  output logic                                  busy,
  output logic                                  err_misalign
);

  localparam int IF_W  = $clog2(MAX_INFLIGHT + 1);
  localparam int IDX_W = (SPS > 2) ? $clog2(SPS) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPS - 1);
  localparam logic [IF_W-1:0]  MAX_IF   = IF_W'(MAX_INFLIGHT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_PAD    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [2*DATA_W-1:0]   tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  tuser_q, tuser_d;
  logic [CNT_W-1:0]      frames_q, frames_d;
  logic [IF_W-1:0]       inflight_q, inflight_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic idx_first_s;
  logic idx_last_s;
  logic out_free_s;
  logic gate_open_s;
  logic frame_go_s;
  logic join_s;
  logic pad_load_s;
  logic load_s;
  logic stream_last_s;
  logic credit_take_s;
  logic credit_ret_s;

  // Transfer qualification: when a joined or pad beat may enter the output register.
  always_comb begin
    idx_first_s   = (idx_q == {IDX_W{1'b0}});
    idx_last_s    = (idx_q == LAST_IDX);
    out_free_s    = !tvalid_q || m_axis_tready;
    // Credits only gate the start of a frame; a frame in progress always finishes.
    gate_open_s   = !idx_first_s || (inflight_q < MAX_IF);
    // Once enable drops, no new frame is opened.
    frame_go_s    = !idx_first_s || enable;
    join_s        = (state_q == ST_STREAM) && s_axis_i_tvalid && s_axis_q_tvalid &&
                    out_free_s && gate_open_s && frame_go_s;
    pad_load_s    = (state_q == ST_PAD) && out_free_s;
    load_s        = join_s || pad_load_s;
    stream_last_s = s_axis_i_tlast || s_axis_q_tlast;
    credit_take_s = load_s && idx_first_s;
    // A return with nothing outstanding is dropped.
    credit_ret_s  = bit_done && (inflight_q != {IF_W{1'b0}});
  end

  // Next-state computation for the FSM, output register, counters and flags.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tdata_d    = tdata_q;
    tvalid_d   = tvalid_q;
    tlast_d    = tlast_q;
    tuser_d    = tuser_q;
    frames_d   = frames_q;
    inflight_d = inflight_q;
    err_d      = err_q;

    if (load_s) begin
      tvalid_d = 1'b1;
      tuser_d  = idx_first_s;
      tlast_d  = idx_last_s;
      tdata_d  = join_s ? {s_axis_i_tdata, s_axis_q_tdata} : {(2*DATA_W){1'b0}};
      idx_d    = idx_last_s ? {IDX_W{1'b0}} : (idx_q + IDX_W'(1));
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end

    if (credit_take_s) begin
      frames_d = frames_q + CNT_W'(1);
    end else begin
      frames_d = frames_q;
    end

    case ({credit_take_s, credit_ret_s})
      2'b10:   inflight_d = inflight_q + IF_W'(1);
      2'b01:   inflight_d = inflight_q - IF_W'(1);
      default: inflight_d = inflight_q;
    endcase

    if (join_s && (s_axis_i_tlast != s_axis_q_tlast)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (join_s) begin
          if (stream_last_s && !idx_last_s) begin
            state_d = ST_PAD;
          end else if (idx_last_s && !enable) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_STREAM;
          end
        end else if (idx_first_s && !enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STREAM;
        end
      end
      ST_PAD: begin
        if (pad_load_s && idx_last_s) begin
          state_d = enable ? ST_STREAM : ST_IDLE;
        end else begin
          state_d = ST_PAD;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops any pending output beat.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      idx_q      <= {IDX_W{1'b0}};
      tdata_q    <= {(2*DATA_W){1'b0}};
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      frames_q   <= {CNT_W{1'b0}};
      inflight_q <= {IF_W{1'b0}};
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      frames_q   <= frames_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  // Both input streams are consumed together, only on a joined transfer.
  assign s_axis_i_tready = join_s;
  assign s_axis_q_tready = join_s;

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;
  assign frames_sent   = frames_q;
  assign in_flight     = inflight_q;
  assign busy          = busy_q;
  assign err_misalign  = err_q;

endmodule

// File: tb/tb_iq_frame_sequencer.sv
`timescale 1ns/1ps
module tb_iq_frame_sequencer;

  localparam int DATA_W       = 16;
  localparam int SPS          = 8;
  localparam int MAX_INFLIGHT = 4;
  localparam int CNT_W        = 16;
  localparam int IF_W         = $clog2(MAX_INFLIGHT + 1);

  logic                clock = 1'b0;
  logic                resetn = 1'b0;
  logic                enable = 1'b0;
  logic [DATA_W-1:0]   s_axis_i_tdata = '0;
  logic                s_axis_i_tvalid = 1'b0;
  logic                s_axis_i_tready;
  logic                s_axis_i_tlast = 1'b0;
  logic [DATA_W-1:0]   s_axis_q_tdata = '0;
  logic                s_axis_q_tvalid = 1'b0;
  logic                s_axis_q_tready;
  logic                s_axis_q_tlast = 1'b0;
  logic [2*DATA_W-1:0] m_axis_tdata;
  logic                m_axis_tvalid;
  logic                m_axis_tready = 1'b0;
  logic                m_axis_tlast;
  logic                m_axis_tuser;
  logic                bit_done = 1'b0;
  logic [CNT_W-1:0]    frames_sent;
  logic [IF_W-1:0]     in_flight;
  logic                busy;
  logic                err_misalign;

  iq_frame_sequencer #(
    .DATA_W(DATA_W), .SPS(SPS), .MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable),
    .s_axis_i_tdata(s_axis_i_tdata), .s_axis_i_tvalid(s_axis_i_tvalid),
    .s_axis_i_tready(s_axis_i_tready), .s_axis_i_tlast(s_axis_i_tlast),
    .s_axis_q_tdata(s_axis_q_tdata), .s_axis_q_tvalid(s_axis_q_tvalid),
    .s_axis_q_tready(s_axis_q_tready), .s_axis_q_tlast(s_axis_q_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .bit_done(bit_done),
    .frames_sent(frames_sent), .in_flight(in_flight), .busy(busy),
    .err_misalign(err_misalign)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Source queues: {tlast, tdata}; the k-th I and k-th Q entries form pair k.
  logic [DATA_W:0]     i_q[$];
  logic [DATA_W:0]     q_q[$];
  // Reference model: expected output beats {tdata, tlast, tuser}.
  logic [2*DATA_W+1:0] exp_q[$];
  int                  mdl_pos    = 0;
  int                  mdl_frames = 0;
  logic                mdl_err    = 1'b0;
  int                  beats_seen = 0;

  int i_gap = 0, q_gap = 0, q_delay = 0, rdy_mode = 0;

  // Frame builder: each pair is a sample, frames are SPS long, and a stream end
  // inside a frame fills the remainder with zero samples.
  task automatic add_pair(input logic [DATA_W-1:0] iv, input logic [DATA_W-1:0] qv,
                          input logic il, input logic ql);
    i_q.push_back({il, iv});
    q_q.push_back({ql, qv});
    if (mdl_pos == 0) mdl_frames++;
    exp_q.push_back({iv, qv, (mdl_pos == SPS-1), (mdl_pos == 0)});
    if (il != ql) mdl_err = 1'b1;
    mdl_pos = (mdl_pos + 1) % SPS;
    if (il || ql) begin
      while (mdl_pos != 0) begin
        exp_q.push_back({{(2*DATA_W){1'b0}}, (mdl_pos == SPS-1), 1'b0});
        mdl_pos = (mdl_pos + 1) % SPS;
      end
    end
  endtask

  task automatic clear_model();
    i_q.delete(); q_q.delete(); exp_q.delete();
    mdl_pos = 0; mdl_frames = 0; mdl_err = 1'b0; beats_seen = 0;
    i_gap = 0; q_gap = 0; q_delay = 0; rdy_mode = 0;
  endtask

  task automatic do_reset();
    @(negedge clock); #2;
    resetn = 1'b0; enable = 1'b0; bit_done = 1'b0;
    clear_model();
    repeat (2) @(posedge clock);
    #3 resetn = 1'b1;
  endtask

  task automatic wait_beats(input int n, input int budget);
    for (int c = 0; c < budget && beats_seen < n; c++) @(posedge clock);
    @(negedge clock);
  endtask

  task automatic pulse_bit_done();
    @(posedge clock); #1 bit_done = 1'b1;
    @(posedge clock); #1 bit_done = 1'b0;
  endtask

  // Source and sink driver: handshakes are sampled mid-cycle, new values driven after the edge.
  initial begin
    logic i_take, q_take;
    int   i_age, rcnt;
    i_age = 0; rcnt = 0;
    forever begin
      @(negedge clock);
      i_take = s_axis_i_tvalid && s_axis_i_tready;
      q_take = s_axis_q_tvalid && s_axis_q_tready;
      @(posedge clock); #1;
      if (!resetn) begin i_take = 1'b0; q_take = 1'b0; end
      if (i_take && i_q.size() > 0) void'(i_q.pop_front());
      if (q_take && q_q.size() > 0) void'(q_q.pop_front());
      if (!resetn || i_take) s_axis_i_tvalid = 1'b0;
      if (!s_axis_i_tvalid) begin
        s_axis_i_tvalid = resetn && (i_q.size() > 0) && (int'($urandom_range(0, 99)) >= i_gap);
        i_age = 0;
      end
      if (i_q.size() == 0) s_axis_i_tvalid = 1'b0;
      if (s_axis_i_tvalid) i_age++;
      if (!resetn || q_take) s_axis_q_tvalid = 1'b0;
      if (!s_axis_q_tvalid)
        s_axis_q_tvalid = resetn && (q_q.size() > 0) && (int'($urandom_range(0, 99)) >= q_gap) &&
                          (q_delay == 0 || i_age > q_delay);
      if (q_q.size() == 0) s_axis_q_tvalid = 1'b0;
      {s_axis_i_tlast, s_axis_i_tdata} = (i_q.size() > 0) ? i_q[0] : '0;
      {s_axis_q_tlast, s_axis_q_tdata} = (q_q.size() > 0) ? q_q[0] : '0;
      case (rdy_mode)
        1:       m_axis_tready = (int'($urandom_range(0, 99)) < 60);
        2:       begin m_axis_tready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3); rcnt++; end
        default: m_axis_tready = 1'b1;
      endcase
    end
  end

  // Output scoreboard, held-beat stability and lone-valid checks.
  initial begin
    logic [2*DATA_W+1:0] held, obs, e;
    logic                held_v;
    held_v = 1'b0; held = '0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        held_v = 1'b0;
      end else begin
        obs = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
        if (held_v) begin
          n_checks++;
          if (!m_axis_tvalid || obs !== held) begin
            n_fail++;
            $display("FAIL hold_stable: got valid=%0b beat=%h, required valid=1 beat=%h", m_axis_tvalid, obs, held);
          end
        end
        if (s_axis_i_tvalid != s_axis_q_tvalid) begin
          n_checks++;
          if (s_axis_i_tready || s_axis_q_tready) begin
            n_fail++;
            $display("FAIL lone_valid: got readies=%0b%0b, required 00", s_axis_i_tready, s_axis_q_tready);
          end
        end
        held_v = m_axis_tvalid && !m_axis_tready;
        held   = obs;
        if (m_axis_tvalid && m_axis_tready) begin
          beats_seen++;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_extra: got beat=%h, required no beat", obs);
          end else begin
            e = exp_q.pop_front();
            if (obs !== e) begin
              n_fail++;
              $display("FAIL beat_%0d: got {tdata,tlast,tuser}=%h, required %h", beats_seen - 1, obs, e);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    #12;
    n_checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== '0) begin
      n_fail++; $display("FAIL reset_out: got %h, required 0", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata});
    end
    n_checks++;
    if ({frames_sent, in_flight, busy, err_misalign, s_axis_i_tready, s_axis_q_tready} !== '0) begin
      n_fail++; $display("FAIL reset_status: got %h, required 0", {frames_sent, in_flight, busy, err_misalign, s_axis_i_tready, s_axis_q_tready});
    end
    @(negedge clock); #2 resetn = 1'b1;
    i_q.push_back({1'b0, 16'h1234});
    q_q.push_back({1'b0, 16'h5678});
    repeat (4) @(negedge clock);
    n_checks++;
    if (busy !== 1'b0 || i_q.size() !== 1) begin
      n_fail++; $display("FAIL idle_hold: got busy=%0b queued=%0d, required busy=0 queued=1", busy, i_q.size());
    end
  endtask

  task automatic test_basic();
    time t0, t1;
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 16; k++) add_pair(DATA_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
    t0 = $time;
    wait_beats(16, 100);
    t1 = $time;
    n_checks++;
    if (beats_seen !== 16) begin n_fail++; $display("FAIL basic_count: got %0d, required 16", beats_seen); end
    n_checks++;
    if ((t1 - t0) / 10 > 20) begin n_fail++; $display("FAIL basic_rate: got %0d cycles, required <= 20", (t1 - t0) / 10); end
    repeat (2) @(negedge clock);
    n_checks++;
    if (frames_sent !== 16'd2) begin n_fail++; $display("FAIL basic_frames: got %0d, required 2", frames_sent); end
    n_checks++;
    if (in_flight !== 3'd2) begin n_fail++; $display("FAIL basic_inflight: got %0d, required 2", in_flight); end
    n_checks++;
    if (busy !== 1'b1 || err_misalign !== 1'b0) begin
      n_fail++; $display("FAIL basic_flags: got busy=%0b err=%0b, required busy=1 err=0", busy, err_misalign);
    end
  endtask

  task automatic test_padding();
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 11; k++) add_pair(DATA_W'($urandom), DATA_W'($urandom), k == 10, k == 10);
    for (int c = 0; c < 100 && beats_seen < 9; c++) @(posedge clock);
    #2 enable = 1'b0;
    wait_beats(16, 100);
    repeat (3) @(negedge clock);
    n_checks++;
    if (beats_seen !== 16 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL pad_count: got %0d beats (%0d missing), required 16", beats_seen, exp_q.size());
    end
    n_checks++;
    if (busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL pad_idle: got busy=%0b tvalid=%0b, required 0 0", busy, m_axis_tvalid);
    end
    n_checks++;
    if (frames_sent !== 16'd2) begin n_fail++; $display("FAIL pad_frames: got %0d, required 2", frames_sent); end
  endtask

  task automatic test_credit();
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 40; k++) add_pair(DATA_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
    repeat (60) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (beats_seen !== 32 || i_q.size() !== 8) begin
      n_fail++; $display("FAIL credit_stop: got beats=%0d left=%0d, required 32 8", beats_seen, i_q.size());
    end
    n_checks++;
    if (s_axis_i_tready !== 1'b0 || s_axis_q_tready !== 1'b0 || in_flight !== 3'd4) begin
      n_fail++; $display("FAIL credit_gate: got readies=%0b%0b inflight=%0d, required 00 4", s_axis_i_tready, s_axis_q_tready, in_flight);
    end
    pulse_bit_done();
    wait_beats(40, 60);
    repeat (2) @(negedge clock);
    n_checks++;
    if (beats_seen !== 40 || i_q.size() !== 0) begin
      n_fail++; $display("FAIL credit_one: got beats=%0d left=%0d, required 40 0", beats_seen, i_q.size());
    end
    n_checks++;
    if (in_flight !== 3'd4 || frames_sent !== 16'd5) begin
      n_fail++; $display("FAIL credit_counts: got inflight=%0d frames=%0d, required 4 5", in_flight, frames_sent);
    end
    pulse_bit_done();
    @(negedge clock);
    n_checks++;
    if (in_flight !== 3'd3) begin n_fail++; $display("FAIL credit_return: got %0d, required 3", in_flight); end
    for (int k = 0; k < 5; k++) begin pulse_bit_done(); @(posedge clock); end
    @(negedge clock);
    n_checks++;
    if (in_flight !== 3'd0) begin n_fail++; $display("FAIL credit_underflow: got %0d, required 0", in_flight); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_mode = 2;
    q_delay  = 3;
    enable   = 1'b1;
    for (int k = 0; k < 24; k++) add_pair(DATA_W'($urandom), DATA_W'($urandom), k == 23, k == 23);
    wait_beats(24, 600);
    repeat (3) @(negedge clock);
    n_checks++;
    if (beats_seen !== 24 || exp_q.size() !== 0) begin
      n_fail++; $display("FAIL bp_count: got %0d beats (%0d missing), required 24", beats_seen, exp_q.size());
    end
    n_checks++;
    if (frames_sent !== 16'd3 || in_flight !== 3'd3) begin
      n_fail++; $display("FAIL bp_counts: got frames=%0d inflight=%0d, required 3 3", frames_sent, in_flight);
    end
  endtask

  task automatic test_misalign();
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 6; k++) add_pair(DATA_W'($urandom), DATA_W'($urandom), k == 5, 1'b0);
    wait_beats(8, 100);
    n_checks++;
    if (beats_seen !== 8 || err_misalign !== mdl_err) begin
      n_fail++; $display("FAIL misalign_pad: got beats=%0d err=%0b, required 8 %0b", beats_seen, err_misalign, mdl_err);
    end
    for (int k = 0; k < 8; k++) add_pair(DATA_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
    wait_beats(16, 100);
    n_checks++;
    if (err_misalign !== 1'b1 || frames_sent !== 16'd2) begin
      n_fail++; $display("FAIL misalign_sticky: got err=%0b frames=%0d, required 1 2", err_misalign, frames_sent);
    end
    do_reset();
    @(negedge clock);
    n_checks++;
    if (err_misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got %0b, required 0", err_misalign); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    enable = 1'b1;
    for (int k = 0; k < 8; k++) add_pair(DATA_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
    for (int c = 0; c < 100 && beats_seen < 3; c++) @(negedge clock);
    n_checks++;
    if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got tvalid=%0b, required 1", m_axis_tvalid); end
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata, frames_sent, in_flight, busy,
         s_axis_i_tready, s_axis_q_tready} !== '0) begin
      n_fail++; $display("FAIL mid_async: got tvalid=%0b tdata=%h frames=%0d inflight=%0d busy=%0b, required all 0",
                         m_axis_tvalid, m_axis_tdata, frames_sent, in_flight, busy);
    end
    enable = 1'b0;
    clear_model();
    repeat (2) @(posedge clock);
    #3 resetn = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 8; k++) add_pair(DATA_W'($urandom), DATA_W'($urandom), 1'b0, 1'b0);
    for (int c = 0; c < 50 && beats_seen < 1; c++) @(negedge clock);
    n_checks++;
    if (beats_seen !== 1 || frames_sent !== 16'd1) begin
      n_fail++; $display("FAIL mid_restart: got beats=%0d frames=%0d, required 1 1", beats_seen, frames_sent);
    end
    wait_beats(8, 50);
    n_checks++;
    if (beats_seen !== 8 || frames_sent !== 16'd1) begin
      n_fail++; $display("FAIL mid_frame: got beats=%0d frames=%0d, required 8 1", beats_seen, frames_sent);
    end
  endtask

  task automatic test_back_to_back();
    int total;
    do_reset();
    i_gap = 30; q_gap = 30; rdy_mode = 1;
    enable = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic l;
      l = (k == 59) || ($urandom_range(0, 9) == 0);
      add_pair(DATA_W'($urandom), DATA_W'($urandom), l, l);
    end
    total = exp_q.size() + beats_seen;
    for (int c = 0; c < 3000 && beats_seen < total; c++) begin
      @(posedge clock); #1 bit_done = ($urandom_range(0, 99) < 25);
    end
    @(posedge clock); #1 bit_done = 1'b0;
    repeat (2) @(negedge clock);
    n_checks++;
    if (beats_seen !== total) begin n_fail++; $display("FAIL rand_count: got %0d, required %0d", beats_seen, total); end
    n_checks++;
    if (frames_sent !== CNT_W'(mdl_frames) || err_misalign !== 1'b0) begin
      n_fail++; $display("FAIL rand_frames: got frames=%0d err=%0b, required %0d 0", frames_sent, err_misalign, mdl_frames);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_padding();
    test_credit();
    test_backpressure();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "time limit");
  end

endmodule
